reorder_buf: RTL
================

REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 Parameter NUM_ENTRIES, default 8: number of ROB entries, power of two.
REQ-002 Parameter IDX_BITS, default 3: log2(NUM_ENTRIES).
REQ-003 Parameter ROBID_BITS, default 7: robid/tag width carried on CDB and to reservation stations.
REQ-004 Parameter VALUE_SIZE, default 32: result width.
REQ-005 Parameter REG_BITS, default 5: architectural register index width.
REQ-006 Ports SHALL be:
- clk  in  1  single clock; all state updates on falling edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_req  in  1  dispatch requests one entry this cycle.
- alloc_dest  in  REG_BITS  architectural destination of the dispatched instruction.
- alloc_robid  out  ROBID_BITS  robid to be given to the next allocation (tail); zero-extended index.
- robfull  out  1  no entry free; feeds reservation stations.
- CDB  in  ROBID_BITS+VALUE_SIZE  {robid, value} broadcast by the execution unit.
- exc_finish  in  1  CDB holds a valid result this cycle.
- src1_robid, src2_robid  in  ROBID_BITS  operand tags to look up.
- src1_rdy, src2_rdy  out  1  tagged value available.
- src1_val, src2_val  out  VALUE_SIZE  tagged value.
- commit_valid  out  1  one-cycle pulse, an entry retired.
- commit_robid  out  ROBID_BITS  retired entry's robid.
- commit_reg  out  REG_BITS  retired entry's destination.
- commit_val  out  VALUE_SIZE  retired entry's result.

Function
REQ-007 Storage SHALL be a circular buffer; each entry holds busy, done, dest, value.
REQ-008 head and tail SHALL be IDX_BITS+1 bits (wrap bit); count = tail-head; robfull = (count == NUM_ENTRIES), combinational from registered pointers.
REQ-009 alloc_robid SHALL equal tail index zero-extended to ROBID_BITS.
REQ-010 On an edge with alloc_req=1 and robfull=0: entry[tail] <= busy=1, done=0, dest=alloc_dest, value=0; tail increments, wrapping NUM_ENTRIES-1 -> 0.
REQ-011 alloc_req with robfull=1 SHALL be ignored; no state change; no retry buffering.
REQ-012 On an edge with exc_finish=1: if CDB robid upper bits are zero and entry[index] is busy and not done, entry SHALL set done=1, value=CDB value; otherwise the CDB is ignored.
REQ-013 A second CDB write to an already-done entry SHALL be ignored (first result wins).
REQ-014 Commit: on an edge where entry[head] is busy and done, commit_valid <= 1, commit_robid/reg/val <= that entry, entry cleared (busy=0, done=0), head increments; otherwise commit_valid <= 0 and commit data holds its previous value.
REQ-015 At most one commit per cycle; minimum latency CDB edge N -> commit_valid high after edge N+1.
REQ-016 Allocation, CDB write and commit in the same edge SHALL all take effect; full/empty decisions use pre-edge state, so a full ROB committing does not accept an allocation that same edge.
REQ-017 CDB targeting the entry allocated on the same edge SHALL be ignored (entry not busy pre-edge).
REQ-018 Lookup (combinational): srcN_rdy=1, srcN_val=CDB value if exc_finish=1 and CDB robid equals srcN_robid; else srcN_rdy=entry.done, srcN_val=entry.value; srcN_rdy=0 if entry not busy or upper robid bits nonzero.
REQ-019 Empty (count 0): no commit; full (count NUM_ENTRIES): robfull=1 until a commit edge.

Reset
REQ-020 rst low SHALL asynchronously clear head, tail, all busy/done bits, commit_valid, commit_robid, commit_reg, commit_val to 0; robfull=0, alloc_robid=0 during and after reset.
REQ-021 Reset mid-operation SHALL discard all in-flight entries; first allocation after release receives robid 0.

Structure
REQ-022 Shared package SHALL hold NUM_ENTRIES, IDX_BITS, ROBID_BITS, VALUE_SIZE, REG_BITS, a rob_entry_t struct (busy, done, dest, value) and a cdb_t struct {robid, value}.
REQ-023 One sub-module rob_ptr (IDX_BITS+1 wrapping counter with increment enable, async active-low clear) SHALL be instantiated for head and tail.

Verification
REQ-024 Reset, then alloc dest=3 -> alloc_robid 0 consumed, next alloc_robid=1, robfull=0.
REQ-025 Alloc robids 0,1; CDB {1,0xAA} then {0,0x55} -> commit robid 0 reg/val 0x55, next cycle robid 1 val 0xAA (in order).
REQ-026 Alloc 8 entries -> robfull=1; 9th alloc_req ignored; complete robid 0 -> commit, robfull=0 one cycle later; next alloc gets robid 0 (wrap).
REQ-027 Lookup src1_robid=2 while exc_finish=1, CDB={2,0x1234}, entry 2 not done -> src1_rdy=1, src1_val=0x1234 same cycle.
REQ-028 CDB {0x45,0x77} (upper bits nonzero) and duplicate CDB to done entry -> no state change, no commit.
REQ-029 Assert rst low with 5 entries busy, mid-cycle -> all outputs 0 immediately; after release first alloc_robid=0.

Source files
------------

// File: rtl/reorder_buf_pkg.sv
// Shared widths and record types for the reorder buffer.
package reorder_buf_pkg;

   localparam int NUM_ENTRIES = 8;
   localparam int IDX_BITS    = 3;
   localparam int ROBID_BITS  = 7;
   localparam int VALUE_SIZE  = 32;
   localparam int REG_BITS    = 5;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic [REG_BITS-1:0]   dest;
      logic [VALUE_SIZE-1:0] value;
   } rob_entry_t;

   typedef struct packed {
      logic [ROBID_BITS-1:0] robid;
      logic [VALUE_SIZE-1:0] value;
   } cdb_t;

endpackage

// File: rtl/reorder_buf_rob_ptr.sv
// Wrapping pointer with an extra wrap bit, used for ROB head and tail.
module rob_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);

   logic [W-1:0] ptr_q, ptr_d;

   // Increment when enabled; the natural binary wrap of W bits gives the ring wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) ptr_d = ptr_q + W'(1);
   end

   // Pointer register, falling-edge clocked like the rest of the ROB.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buf.sv
// In-order retirement buffer: allocate at tail, complete via CDB, retire from head.
module reorder_buf
   import reorder_buf_pkg::rob_entry_t;
   import reorder_buf_pkg::cdb_t;
#(
   parameter int NUM_ENTRIES = reorder_buf_pkg::NUM_ENTRIES,
   parameter int IDX_BITS    = reorder_buf_pkg::IDX_BITS,
   parameter int ROBID_BITS  = reorder_buf_pkg::ROBID_BITS,
   parameter int VALUE_SIZE  = reorder_buf_pkg::VALUE_SIZE,
   parameter int REG_BITS    = reorder_buf_pkg::REG_BITS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alloc_req,
   input  logic [REG_BITS-1:0]            alloc_dest,
   output logic [ROBID_BITS-1:0]          alloc_robid,
   output logic                           robfull,
   input  logic [ROBID_BITS+VALUE_SIZE-1:0] CDB,
   input  logic                           exc_finish,
   input  logic [ROBID_BITS-1:0]          src1_robid,
   input  logic [ROBID_BITS-1:0]          src2_robid,
   output logic                           src1_rdy,
   output logic                           src2_rdy,
   output logic [VALUE_SIZE-1:0]          src1_val,
   output logic [VALUE_SIZE-1:0]          src2_val,
   output logic                           commit_valid,
   output logic [ROBID_BITS-1:0]          commit_robid,
   output logic [REG_BITS-1:0]            commit_reg,
   output logic [VALUE_SIZE-1:0]          commit_val
);

   localparam logic [IDX_BITS:0] FULL_CNT = (IDX_BITS+1)'(NUM_ENTRIES);

   rob_entry_t entry_q [NUM_ENTRIES];
   rob_entry_t entry_d [NUM_ENTRIES];

   logic [IDX_BITS:0]     head, tail, count;
   logic [IDX_BITS-1:0]   head_idx, tail_idx, cdb_idx, src1_idx, src2_idx;
   logic                  alloc_en, cdb_hit, commit_en;
   logic                  cdb_in_range, src1_in_range, src2_in_range;
   cdb_t                  cdb;

   logic                  commit_valid_q, commit_valid_d;
   logic [ROBID_BITS-1:0] commit_robid_q, commit_robid_d;
   logic [REG_BITS-1:0]   commit_reg_q, commit_reg_d;
   logic [VALUE_SIZE-1:0] commit_val_q, commit_val_d;

   assign cdb      = CDB;
   assign head_idx = head[IDX_BITS-1:0];
   assign tail_idx = tail[IDX_BITS-1:0];
   assign cdb_idx  = cdb.robid[IDX_BITS-1:0];
   assign src1_idx = src1_robid[IDX_BITS-1:0];
   assign src2_idx = src2_robid[IDX_BITS-1:0];

   // A tag only names a ROB slot when the bits above the index are zero.
   assign cdb_in_range  = (cdb.robid  >> IDX_BITS) == '0;
   assign src1_in_range = (src1_robid >> IDX_BITS) == '0;
   assign src2_in_range = (src2_robid >> IDX_BITS) == '0;

   assign count       = tail - head;
   assign robfull     = (count == FULL_CNT);
   assign alloc_robid = ROBID_BITS'(tail_idx);

   // All accept/complete/retire decisions look only at pre-edge state.
   assign alloc_en  = alloc_req && !robfull;
   assign cdb_hit   = exc_finish && cdb_in_range && entry_q[cdb_idx].busy && !entry_q[cdb_idx].done;
   assign commit_en = entry_q[head_idx].busy && entry_q[head_idx].done;

   rob_ptr #(.W(IDX_BITS+1)) u_head (.clk(clk), .rst(rst), .inc_i(commit_en), .ptr_o(head));
   rob_ptr #(.W(IDX_BITS+1)) u_tail (.clk(clk), .rst(rst), .inc_i(alloc_en),  .ptr_o(tail));

   // Entry updates; alloc (free slot), CDB (busy, not done) and commit (done) never collide.
   always_comb begin
      entry_d = entry_q;
      if (alloc_en) begin
         entry_d[tail_idx].busy  = 1'b1;
         entry_d[tail_idx].done  = 1'b0;
         entry_d[tail_idx].dest  = alloc_dest;
         entry_d[tail_idx].value = '0;
      end
      if (cdb_hit) begin
         entry_d[cdb_idx].done  = 1'b1;
         entry_d[cdb_idx].value = cdb.value;
      end
      if (commit_en) begin
         entry_d[head_idx].busy = 1'b0;
         entry_d[head_idx].done = 1'b0;
      end
   end

   // Retire port: pulse valid, hold data between retirements.
   always_comb begin
      commit_valid_d = commit_en;
      commit_robid_d = commit_robid_q;
      commit_reg_d   = commit_reg_q;
      commit_val_d   = commit_val_q;
      if (commit_en) begin
         commit_robid_d = ROBID_BITS'(head_idx);
         commit_reg_d   = entry_q[head_idx].dest;
         commit_val_d   = entry_q[head_idx].value;
      end
   end

   // ROB storage and retire registers, updated on the falling edge.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
         commit_valid_q <= 1'b0;
         commit_robid_q <= '0;
         commit_reg_q   <= '0;
         commit_val_q   <= '0;
      end else begin
         entry_q        <= entry_d;
         commit_valid_q <= commit_valid_d;
         commit_robid_q <= commit_robid_d;
         commit_reg_q   <= commit_reg_d;
         commit_val_q   <= commit_val_d;
      end
   end

   // Operand lookup with same-cycle CDB bypass; only live slots can report ready.
   always_comb begin
      src1_rdy = 1'b0;
      src1_val = entry_q[src1_idx].value;
      src2_rdy = 1'b0;
      src2_val = entry_q[src2_idx].value;
      if (exc_finish && cdb.robid == src1_robid) src1_val = cdb.value;
      if (exc_finish && cdb.robid == src2_robid) src2_val = cdb.value;
      if (src1_in_range && entry_q[src1_idx].busy)
         src1_rdy = entry_q[src1_idx].done || (exc_finish && cdb.robid == src1_robid);
      if (src2_in_range && entry_q[src2_idx].busy)
         src2_rdy = entry_q[src2_idx].done || (exc_finish && cdb.robid == src2_robid);
   end

   assign commit_valid = commit_valid_q;
   assign commit_robid = commit_robid_q;
   assign commit_reg   = commit_reg_q;
   assign commit_val   = commit_val_q;

endmodule
